// File: rtl/race_decoder.sv
// race_decoder: gamma-cycle timebase plus first-arrival time decoder for a race-logic comparator.
// Latency: the result of a gamma cycle appears on out_data/out_valid during slot 0 of the next cycle.
// Backpressure: one-entry output register; a new result that finds it full and unaccepted is dropped and sets sticky ovf.
//
// Ports:
//   aclk, grst_n        clock, asynchronous active-low reset
//   en                  run enable (level); a gamma cycle in progress always completes
//   y                   comparator output, sampled on aclk
//   gamma_rst           high in the last slot of each running gamma cycle (comparator latch reset)
//   out_valid/out_ready/out_data  result handshake; out_data = arrival slot, or GAMMA_CYCLE_WIDTH for no edge
//   ovf, ovf_clr        sticky dropped-result flag and its synchronous clear (set has priority)
//
// Build option: RACE_DECODER_GLITCH_FILTER_EN requires y high on two consecutive slots
// of the same gamma cycle; the first of the two slots is reported.

module race_decoder #(
  parameter  int GAMMA_CYCLE_WIDTH = 16,
  localparam int CW                = $clog2(GAMMA_CYCLE_WIDTH + 1)
) (
  input  logic          aclk,
  input  logic          grst_n,
  input  logic          en,
  input  logic          y,
  output logic          gamma_rst,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_data,
  output logic          ovf,
  input  logic          ovf_clr
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Slot G-1 and the "no edge" code, sized to the counter so the end-of-cycle
  // compare is explicit rather than relying on a power-of-two wrap.
  localparam logic [CW-1:0] LAST_SLOT = CW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [CW-1:0] NO_EDGE   = CW'(GAMMA_CYCLE_WIDTH);

  state_t        state_q, state_d;
  logic [CW-1:0] t_cnt_q, t_cnt_d;
  logic          captured_q;
  logic [CW-1:0] cap_time_q;

  logic          run;
  logic          last;
  logic          hit;
  logic [CW-1:0] hit_time;
  logic [CW-1:0] result;
  logic          take;

  assign run       = (state_q == S_RUN);
  assign last      = run && (t_cnt_q == LAST_SLOT);
  assign gamma_rst = last;

  // ---------------------------------------------------------------------------
  // Timebase FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q <= S_IDLE;
      t_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      t_cnt_q <= t_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_cnt_d = t_cnt_q;
    case (state_q)
      S_IDLE: begin
        t_cnt_d = '0;
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (t_cnt_q == LAST_SLOT) begin
          // en is only looked at on the wrap edge, so a cycle is never cut short.
          t_cnt_d = '0;
          if (!en) state_d = S_IDLE;
        end else begin
          t_cnt_d = t_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        t_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Edge qualification
  // ---------------------------------------------------------------------------
`ifdef RACE_DECODER_GLITCH_FILTER_EN
  // Previous-slot sample of y and the slot it came from. Cleared at the wrap
  // and while idle so a pulse can never be confirmed across gamma cycles.
  logic          prev_y_q;
  logic [CW-1:0] prev_slot_q;

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      prev_y_q    <= 1'b0;
      prev_slot_q <= '0;
    end else if (!run || last) begin
      prev_y_q    <= 1'b0;
      prev_slot_q <= '0;
    end else begin
      prev_y_q    <= y;
      prev_slot_q <= t_cnt_q;
    end
  end

  assign hit      = y && prev_y_q;
  assign hit_time = prev_slot_q;
`else
  assign hit      = y;
  assign hit_time = t_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // First-arrival capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      captured_q <= 1'b0;
      cap_time_q <= '0;
    end else if (last) begin
      captured_q <= 1'b0;
    end else if (run && hit && !captured_q) begin
      captured_q <= 1'b1;
      cap_time_q <= hit_time;
    end
  end

  // The sample taken on the wrap edge still counts, so it is folded in here
  // instead of going through the capture register.
  always_comb begin
    result = NO_EDGE;
    if (captured_q)  result = cap_time_q;
    else if (hit)    result = hit_time;
  end

  // ---------------------------------------------------------------------------
  // One-entry output register with sticky overflow
  // ---------------------------------------------------------------------------
  assign take = out_valid && out_ready;

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (last) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_data  <= result;
      end
    end else if (take) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      ovf <= 1'b0;
    end else if (last && out_valid && !out_ready) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule
